ova_dvp_capture: RTL and testbench

//  Parametrised DVP camera capture engine for the OVA sensor path, a generalised successor to the fixed 8-bit pclk-domain reader.

---
 rtl/ova_dvp_capture.sv | 240 ++++++++++++++++++++++++
 tb/tb_ova_dvp_capture.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ova_dvp_capture.sv
// DVP camera capture engine: oversamples pclk/href/vsync on the system clock, assembles
// multi-byte pixels, applies a crop window and frame decimation, and emits tagged pixels.
module ova_dvp_capture #(
    parameter int unsigned DATA_W        = 8,
    parameter int unsigned BYTES_PER_PIX = 2,
    parameter int unsigned CNT_W         = 12,
    parameter int unsigned SKIP_W        = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              i_pclk,
    input  logic [DATA_W-1:0]                 i_data,
    input  logic                              i_href,
    input  logic                              i_vsync,
    input  logic                              i_cap_en,
    input  logic [CNT_W-1:0]                  i_win_x0,
    input  logic [CNT_W-1:0]                  i_win_y0,
    input  logic [CNT_W-1:0]                  i_win_w,
    input  logic [CNT_W-1:0]                  i_win_h,
    input  logic [SKIP_W-1:0]                 i_skip,
    input  logic                              i_pix_rdy,
    output logic [DATA_W*BYTES_PER_PIX-1:0]   o_pix_data,
    output logic                              o_pix_vld,
    output logic                              o_sof,
    output logic                              o_eol,
    output logic                              o_eof,
    output logic                              o_buf_sel,
    output logic                              o_frame_done,
    output logic [15:0]                       o_frame_cnt,
    output logic                              o_overflow,
    output logic                              o_busy
);

    localparam int unsigned PIX_W = DATA_W * BYTES_PER_PIX;
    localparam int unsigned IDX_W = 2;
    localparam int unsigned CW1   = CNT_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_PIX - 1);

    typedef enum logic [1:0] {IDLE, VS_WAIT, ACTIVE, DONE} state_t;

    state_t state, state_d;
    logic   frame_start;

    logic [2:0]        pclk_sr, href_sr, vs_sr;
    logic [DATA_W-1:0] data_s1, data_s2;

    logic [CNT_W-1:0]  win_x0, win_y0, win_w, win_h;
    logic [SKIP_W-1:0] skip_l, skip_cnt;
    logic              skip_frame;

    logic [IDX_W-1:0]  byte_idx, idx_base;
    logic [CNT_W-1:0]  x, y, x_base;
    logic [PIX_W-1:0]  shreg, sh_next;
    logic              byte_take, pix_complete;

    logic              pix_done;
    logic [PIX_W-1:0]  pix_word;
    logic [CNT_W-1:0]  pix_x, pix_y;

    logic [CW1-1:0]    px, py, x_lo, x_hi, y_lo, y_hi;
    logic              in_win, eol, eof, emit, hold, sof_pend;

    logic pclk_rise, href_rise, href_fall, vs_rise, vs_fall;

    // Identical 2-FF synchronisers; stage 3 only feeds edge detection
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pclk_sr <= '0;
            href_sr <= '0;
            vs_sr   <= '0;
            data_s1 <= '0;
            data_s2 <= '0;
        end else begin
            pclk_sr <= {pclk_sr[1:0], i_pclk};
            href_sr <= {href_sr[1:0], i_href};
            vs_sr   <= {vs_sr[1:0], i_vsync};
            data_s1 <= i_data;
            data_s2 <= data_s1;
        end
    end

    always_comb begin
        pclk_rise = pclk_sr[1] & ~pclk_sr[2];
        href_rise = href_sr[1] & ~href_sr[2];
        href_fall = ~href_sr[1] & href_sr[2];
        vs_rise   = vs_sr[1] & ~vs_sr[2];
        vs_fall   = ~vs_sr[1] & vs_sr[2];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d     = state;
        frame_start = 1'b0;
        case (state)
            IDLE:    if (vs_rise && i_cap_en) state_d = VS_WAIT;
            VS_WAIT: if (vs_fall) begin
                         state_d     = ACTIVE;
                         frame_start = 1'b1;
                     end
            ACTIVE:  if (vs_rise) state_d = DONE;
            DONE:    state_d = i_cap_en ? VS_WAIT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Frame configuration and decimation bookkeeping
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win_x0       <= '0;
            win_y0       <= '0;
            win_w        <= '0;
            win_h        <= '0;
            skip_l       <= '0;
            skip_cnt     <= '0;
            skip_frame   <= 1'b0;
            o_frame_done <= 1'b0;
            o_frame_cnt  <= '0;
            o_buf_sel    <= 1'b0;
            o_busy       <= 1'b0;
        end else begin
            o_frame_done <= 1'b0;
            o_busy       <= (state_d != IDLE);
            if (frame_start) begin
                win_x0     <= i_win_x0;
                win_y0     <= i_win_y0;
                win_w      <= i_win_w;
                win_h      <= i_win_h;
                skip_l     <= i_skip;
                skip_frame <= (skip_cnt != '0);
            end
            if (state == DONE) begin
                skip_cnt <= (skip_cnt == skip_l) ? '0 : skip_cnt + SKIP_W'(1);
                if (!skip_frame) begin
                    o_frame_done <= 1'b1;
                    o_frame_cnt  <= o_frame_cnt + 16'd1;
                    o_buf_sel    <= ~o_buf_sel;
                end
            end
        end
    end

    // An href rise in the same cycle as a byte restarts the line on that byte
    always_comb begin
        idx_base     = href_rise ? '0 : byte_idx;
        x_base       = href_rise ? '0 : x;
        sh_next      = (shreg << DATA_W) | PIX_W'(data_s2);
        byte_take    = (state == ACTIVE) && pclk_rise && href_sr[1];
        pix_complete = byte_take && (idx_base == LAST_IDX);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            byte_idx <= '0;
            x        <= '0;
            y        <= '0;
            shreg    <= '0;
            pix_done <= 1'b0;
            pix_word <= '0;
            pix_x    <= '0;
            pix_y    <= '0;
        end else begin
            pix_done <= 1'b0;
            if (frame_start) begin
                byte_idx <= '0;
                x        <= '0;
                y        <= '0;
            end else if (state == ACTIVE) begin
                if (href_fall) y <= y + CNT_W'(1);
                if (byte_take) begin
                    shreg <= sh_next;
                    if (pix_complete) begin
                        byte_idx <= '0;
                        x        <= x_base + CNT_W'(1);
                        pix_done <= 1'b1;
                        pix_word <= sh_next;
                        pix_x    <= x_base;
                        pix_y    <= y;
                    end else begin
                        byte_idx <= idx_base + IDX_W'(1);
                        x        <= x_base;
                    end
                end else if (href_rise) begin
                    byte_idx <= '0;
                    x        <= '0;
                end
            end
        end
    end

    // Window test at CNT_W+1 bits so x0+w never wraps
    always_comb begin
        px     = CW1'(pix_x);
        py     = CW1'(pix_y);
        x_lo   = CW1'(win_x0);
        y_lo   = CW1'(win_y0);
        x_hi   = CW1'(win_x0) + CW1'(win_w);
        y_hi   = CW1'(win_y0) + CW1'(win_h);
        in_win = !skip_frame && (px >= x_lo) && (px < x_hi) && (py >= y_lo) && (py < y_hi);
        eol    = (px == x_hi - CW1'(1));
        eof    = eol && (py == y_hi - CW1'(1));
        emit   = pix_done && in_win;
        hold   = o_pix_vld && !i_pix_rdy;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_pix_data <= '0;
            o_pix_vld  <= 1'b0;
            o_sof      <= 1'b0;
            o_eol      <= 1'b0;
            o_eof      <= 1'b0;
            o_overflow <= 1'b0;
            sof_pend   <= 1'b0;
        end else begin
            if (frame_start) begin
                o_overflow <= 1'b0;
                sof_pend   <= 1'b1;
            end
            if (emit) begin
                if (hold) begin
                    o_overflow <= 1'b1;
                end else begin
                    o_pix_data <= pix_word;
                    o_pix_vld  <= 1'b1;
                    o_sof      <= sof_pend;
                    o_eol      <= eol;
                    o_eof      <= eof;
                    sof_pend   <= 1'b0;
                end
            end else if (o_pix_vld && i_pix_rdy) begin
                o_pix_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ova_dvp_capture.sv
// Scoreboard bench for ova_dvp_capture: a camera driver predicts each pixel from the
// window/decimation rules and queues it; a monitor pops and compares on every transfer.
module tb_ova_dvp_capture;

    localparam int unsigned DW  = 8;
    localparam int unsigned BPP = 2;
    localparam int unsigned CW  = 12;
    localparam int unsigned SW  = 4;
    localparam int unsigned PW  = DW * BPP;

    typedef struct packed {
        logic [PW-1:0] data;
        logic          sof;
        logic          eol;
        logic          eof;
        logic          ovf;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          i_pclk;
    logic [DW-1:0] i_data;
    logic          i_href;
    logic          i_vsync;
    logic          i_cap_en;
    logic [CW-1:0] i_win_x0, i_win_y0, i_win_w, i_win_h;
    logic [SW-1:0] i_skip;
    logic          i_pix_rdy;
    logic [PW-1:0] o_pix_data;
    logic          o_pix_vld, o_sof, o_eol, o_eof;
    logic          o_buf_sel, o_frame_done, o_overflow, o_busy;
    logic [15:0]   o_frame_cnt;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   done_cnt = 0;
    int   exp_done = 0;
    int   exp_fc   = 0;
    int   rdy_mode = 0;
    int   wx0, wy0, ww, wh;

    ova_dvp_capture #(
        .DATA_W(DW), .BYTES_PER_PIX(BPP), .CNT_W(CW), .SKIP_W(SW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_pclk(i_pclk), .i_data(i_data),
        .i_href(i_href), .i_vsync(i_vsync), .i_cap_en(i_cap_en),
        .i_win_x0(i_win_x0), .i_win_y0(i_win_y0), .i_win_w(i_win_w), .i_win_h(i_win_h),
        .i_skip(i_skip), .i_pix_rdy(i_pix_rdy),
        .o_pix_data(o_pix_data), .o_pix_vld(o_pix_vld), .o_sof(o_sof), .o_eol(o_eol),
        .o_eof(o_eof), .o_buf_sel(o_buf_sel), .o_frame_done(o_frame_done),
        .o_frame_cnt(o_frame_cnt), .o_overflow(o_overflow), .o_busy(o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    endtask

    function automatic logic [63:0] all_outputs();
        return 64'({o_pix_data, o_pix_vld, o_sof, o_eol, o_eof, o_buf_sel,
                    o_frame_done, o_frame_cnt, o_overflow, o_busy});
    endfunction

    // Ready driver: 0 = always ready, 1 = random with short low runs, 2 = held low
    int low_run = 0;
    always @(posedge clk) begin
        #2;
        case (rdy_mode)
            1: begin
                if (low_run >= 3 || $urandom_range(0, 1) == 1) begin
                    i_pix_rdy = 1'b1;
                    low_run   = 0;
                end else begin
                    i_pix_rdy = 1'b0;
                    low_run++;
                end
            end
            2:       i_pix_rdy = 1'b0;
            default: i_pix_rdy = 1'b1;
        endcase
    end

    // Monitor: compares every transfer against the queue and checks held outputs stay put
    logic          prev_hold = 1'b0;
    logic [PW+2:0] prev_out;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_hold = 1'b0;
        end else begin
            if (o_frame_done) done_cnt++;
            if (prev_hold)
                check("hold_stable", 64'({o_pix_vld, o_pix_data, o_sof, o_eol, o_eof}),
                      64'({1'b1, prev_out}));
            if (o_pix_vld && i_pix_rdy) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pixel", 64'(o_pix_data), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("pix_data", 64'(o_pix_data), 64'(e.data));
                    check("pix_tags", 64'({o_sof, o_eol, o_eof, o_overflow}),
                          64'({e.sof, e.eol, e.eof, e.ovf}));
                end
            end
            prev_hold = o_pix_vld && !i_pix_rdy;
            prev_out  = {o_pix_data, o_sof, o_eol, o_eof};
        end
    end

    // One camera frame; cap says whether the decimation rule selects it
    task automatic send_frame(input int npix, input int nrows, input bit odd, input bit cap,
                              input int stall, input int rst_row, input bit fixed);
        int          k;
        int          nb;
        int          px;
        bit          sof_pend;
        bit          dropped;
        bit          cap_l;
        logic [31:0] pv;
        logic [7:0]  b;
        exp_t        e;
        k        = 0;
        sof_pend = 1'b1;
        dropped  = 1'b0;
        cap_l    = cap;
        i_win_x0 = CW'(wx0);
        i_win_y0 = CW'(wy0);
        i_win_w  = CW'(ww);
        i_win_h  = CW'(wh);
        i_vsync  = 1'b1;
        repeat (20) tick();
        if (stall > 0) rdy_mode = 2;
        i_vsync = 1'b0;
        repeat (20) tick();
        for (int r = 0; r < nrows; r++) begin
            if (r == rst_row) begin
                rst_n = 1'b0;
                tick();
                check("reset_mid_frame", all_outputs(), 64'd0);
                rst_n = 1'b1;
                exp_q.delete();
                exp_fc = 0;
                cap_l  = 1'b0;
            end
            nb     = npix * BPP + (odd ? 1 : 0);
            pv     = '0;
            i_href = 1'b1;
            for (int bi = 0; bi < nb; bi++) begin
                b = 8'($urandom);
                if (fixed && r == 0 && bi < 2) b = (bi == 0) ? 8'h12 : 8'h34;
                i_data = b;
                i_pclk = 1'b0;
                repeat (4) tick();
                i_pclk = 1'b1;
                repeat (4) tick();
                pv = (pv << 8) | 32'(b);
                if ((bi % BPP) == BPP - 1 && bi < npix * BPP) begin
                    px = bi / BPP;
                    if (cap_l && px >= wx0 && px < wx0 + ww && r >= wy0 && r < wy0 + wh) begin
                        if (stall > 0 && k > 0 && k < stall) begin
                            dropped = 1'b1;
                        end else begin
                            e.data   = PW'(pv);
                            e.sof    = sof_pend;
                            e.eol    = (px == wx0 + ww - 1);
                            e.eof    = e.eol && (r == wy0 + wh - 1);
                            e.ovf    = (stall > 1);
                            sof_pend = 1'b0;
                            exp_q.push_back(e);
                        end
                        if (stall > 0 && k == stall - 1) rdy_mode = 0;
                        k++;
                    end
                    pv = '0;
                end
            end
            i_pclk = 1'b0;
            i_href = 1'b0;
            repeat (12) tick();
        end
        i_vsync = 1'b1;
        repeat (12) tick();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick();
        if (cap_l) begin
            exp_fc++;
            exp_done++;
        end
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        check("frame_cnt", 64'(o_frame_cnt), 64'(exp_fc));
        check("buf_sel", 64'(o_buf_sel), 64'(exp_fc % 2));
        check("frame_done_pulses", 64'(done_cnt), 64'(exp_done));
        check("overflow", 64'(o_overflow), 64'(dropped));
        check("busy", 64'(o_busy), 64'd1);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n    = 1'b0;
        i_pclk   = 1'b0;
        i_data   = '0;
        i_href   = 1'b0;
        i_vsync  = 1'b0;
        i_cap_en = 1'b1;
        i_skip   = '0;
        wx0 = 0; wy0 = 0; ww = 8; wh = 4;
        i_win_x0 = '0; i_win_y0 = '0; i_win_w = '0; i_win_h = '0;
        repeat (3) tick();
        check("reset_outputs", all_outputs(), 64'd0);
        rst_n = 1'b1;
        tick();

        // Full 8x4 window, first pixel 0x1234
        send_frame(8, 4, 1'b0, 1'b1, 0, -1, 1'b1);

        // Cropped window
        wx0 = 2; wy0 = 1; ww = 3; wh = 2;
        send_frame(8, 4, 1'b0, 1'b1, 0, -1, 1'b0);

        // Random windows including empty and overhanging ones
        for (int f = 0; f < 5; f++) begin
            wx0 = $urandom_range(0, 9);
            wy0 = $urandom_range(0, 4);
            ww  = $urandom_range(0, 9);
            wh  = $urandom_range(0, 5);
            send_frame(8, 4, 1'b0, 1'b1, 0, -1, 1'b0);
        end

        // Odd trailing byte per line is discarded
        wx0 = 0; wy0 = 0; ww = 8; wh = 4;
        send_frame(1, 4, 1'b1, 1'b1, 0, -1, 1'b0);
        send_frame(8, 4, 1'b1, 1'b1, 0, -1, 1'b0);

        // Back-pressure: first pixel held, next two dropped; next frame clean
        send_frame(8, 4, 1'b0, 1'b1, 3, -1, 1'b0);
        send_frame(8, 4, 1'b0, 1'b1, 0, -1, 1'b0);

        // Random short back-pressure with random windows
        rdy_mode = 1;
        for (int f = 0; f < 3; f++) begin
            wx0 = $urandom_range(0, 4);
            wy0 = $urandom_range(0, 2);
            ww  = $urandom_range(1, 8);
            wh  = $urandom_range(1, 4);
            send_frame(8, 4, 1'b0, 1'b1, 0, -1, 1'b0);
        end
        rdy_mode = 0;

        // Reset in mid frame, then a clean frame after a full vsync cycle
        wx0 = 0; wy0 = 0; ww = 8; wh = 4;
        send_frame(8, 4, 1'b0, 1'b1, 0, 2, 1'b0);
        i_skip = SW'(2);
        // Decimation: 1 of every 3 frames since reset
        for (int f = 0; f < 6; f++)
            send_frame(8, 4, 1'b0, (f % 3) == 0, 0, -1, 1'b0);
        check("skip_frame_cnt", 64'(o_frame_cnt), 64'd2);
        check("skip_buf_sel", 64'(o_buf_sel), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
